// File: rtl/rf_ex_stage_if.sv
// Signal bundle between ID/RF, the forwarding network and the RF_EX register.
// slave is the pipeline-register side; master is the driving environment.
interface rf_ex_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] opA_RF, opB_RF, opC_RF, opD_RF;
  logic [2:0]        mux_controller_A, mux_controller_B, mux_controller_C, mux_controller_D;
  logic [DATA_W-1:0] alu_1_EX, alu_2_EX, data_1_EX_M, data_2_EX_M, data_1_M_WB, data_2_M_WB;
  logic              valid1_ID_RF, valid2_ID_RF, wb_1_ID_RF, wb_2_ID_RF, load_1_ID_RF, load_2_ID_RF;
  logic [2:0]        dest_1_ID_RF, dest_2_ID_RF;
  logic              flush, ex_hold;

  logic [DATA_W-1:0] opA_RF_EX, opB_RF_EX, opC_RF_EX, opD_RF_EX;
  logic              valid1_RF_EX, valid2_RF_EX, wb_1_RF_EX, wb_2_RF_EX, load_1_RF_EX, load_2_RF_EX;
  logic [2:0]        dest_1_RF_EX, dest_2_RF_EX;
  logic              stall_ID;
  logic [15:0]       stall_count;

  modport slave (
    input  opA_RF, opB_RF, opC_RF, opD_RF,
           mux_controller_A, mux_controller_B, mux_controller_C, mux_controller_D,
           alu_1_EX, alu_2_EX, data_1_EX_M, data_2_EX_M, data_1_M_WB, data_2_M_WB,
           valid1_ID_RF, valid2_ID_RF, wb_1_ID_RF, wb_2_ID_RF, load_1_ID_RF, load_2_ID_RF,
           dest_1_ID_RF, dest_2_ID_RF, flush, ex_hold,
    output opA_RF_EX, opB_RF_EX, opC_RF_EX, opD_RF_EX,
           valid1_RF_EX, valid2_RF_EX, wb_1_RF_EX, wb_2_RF_EX, load_1_RF_EX, load_2_RF_EX,
           dest_1_RF_EX, dest_2_RF_EX, stall_ID, stall_count
  );

  modport master (
    output opA_RF, opB_RF, opC_RF, opD_RF,
           mux_controller_A, mux_controller_B, mux_controller_C, mux_controller_D,
           alu_1_EX, alu_2_EX, data_1_EX_M, data_2_EX_M, data_1_M_WB, data_2_M_WB,
           valid1_ID_RF, valid2_ID_RF, wb_1_ID_RF, wb_2_ID_RF, load_1_ID_RF, load_2_ID_RF,
           dest_1_ID_RF, dest_2_ID_RF, flush, ex_hold,
    input  opA_RF_EX, opB_RF_EX, opC_RF_EX, opD_RF_EX,
           valid1_RF_EX, valid2_RF_EX, wb_1_RF_EX, wb_2_RF_EX, load_1_RF_EX, load_2_RF_EX,
           dest_1_RF_EX, dest_2_RF_EX, stall_ID, stall_count
  );
endinterface

// File: rtl/rf_ex_stage.sv
// RF->EX pipeline register of a two-lane core: resolves forwarded operands,
// inserts a one-cycle bubble on load-use hazards and counts those stalls.
module rf_ex_stage #(
  parameter int          DATA_W         = 16,
  parameter logic [15:0] STALL_CNT_INIT = 16'h0000
) (
  input logic          clk,
  input logic          rst_n,
  rf_ex_stage_if.slave bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  function automatic logic [DATA_W-1:0] resolve(
    input logic [2:0]        sel,
    input logic [DATA_W-1:0] rf_val,
    input logic [DATA_W-1:0] alu1, alu2, exm1, exm2, mwb1, mwb2
  );
    logic [DATA_W-1:0] res;
    case (sel)
      3'b001:  res = alu1;
      3'b010:  res = alu2;
      3'b011:  res = exm1;
      3'b100:  res = exm2;
      3'b101:  res = mwb1;
      3'b110:  res = mwb2;
      default: res = rf_val;
    endcase
    return res;
  endfunction

  function automatic logic reads_code(input logic [2:0] sel_a, input logic [2:0] sel_b,
                                      input logic [2:0] code);
    return (sel_a == code) || (sel_b == code);
  endfunction

  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d, op_d_q, op_d_d;
  logic [DATA_W-1:0] res_a_s, res_b_s, res_c_s, res_d_s;
  logic [2:0]        dest_1_q, dest_1_d, dest_2_q, dest_2_d;
  logic              valid_1_q, valid_1_d, valid_2_q, valid_2_d;
  logic              wb_1_q, wb_1_d, wb_2_q, wb_2_d;
  logic              load_1_q, load_1_d, load_2_q, load_2_d;
  logic [0:0]        state_q, state_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              lu_1_s, lu_2_s, lu_s, stall_s;

  assign res_a_s = resolve(bus.mux_controller_A, bus.opA_RF, bus.alu_1_EX, bus.alu_2_EX,
                           bus.data_1_EX_M, bus.data_2_EX_M, bus.data_1_M_WB, bus.data_2_M_WB);
  assign res_b_s = resolve(bus.mux_controller_B, bus.opB_RF, bus.alu_1_EX, bus.alu_2_EX,
                           bus.data_1_EX_M, bus.data_2_EX_M, bus.data_1_M_WB, bus.data_2_M_WB);
  assign res_c_s = resolve(bus.mux_controller_C, bus.opC_RF, bus.alu_1_EX, bus.alu_2_EX,
                           bus.data_1_EX_M, bus.data_2_EX_M, bus.data_1_M_WB, bus.data_2_M_WB);
  assign res_d_s = resolve(bus.mux_controller_D, bus.opD_RF, bus.alu_1_EX, bus.alu_2_EX,
                           bus.data_1_EX_M, bus.data_2_EX_M, bus.data_1_M_WB, bus.data_2_M_WB);

  // A lane hazards when it forwards from an EX slot that still holds a load.
  assign lu_1_s = bus.valid1_ID_RF &&
      ((reads_code(bus.mux_controller_A, bus.mux_controller_B, 3'b001) && valid_1_q && load_1_q) ||
       (reads_code(bus.mux_controller_A, bus.mux_controller_B, 3'b010) && valid_2_q && load_2_q));
  assign lu_2_s = bus.valid2_ID_RF &&
      ((reads_code(bus.mux_controller_C, bus.mux_controller_D, 3'b001) && valid_1_q && load_1_q) ||
       (reads_code(bus.mux_controller_C, bus.mux_controller_D, 3'b010) && valid_2_q && load_2_q));
  assign lu_s = lu_1_s || lu_2_s;

  always_comb begin
    op_a_d = op_a_q;   op_b_d = op_b_q;   op_c_d = op_c_q;   op_d_d = op_d_q;
    dest_1_d = dest_1_q;   dest_2_d = dest_2_q;
    valid_1_d = valid_1_q; valid_2_d = valid_2_q;
    wb_1_d = wb_1_q;       wb_2_d = wb_2_q;
    load_1_d = load_1_q;   load_2_d = load_2_q;
    state_d = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_s = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b0;
    end else if (bus.flush) begin
      valid_1_d = 1'b0; valid_2_d = 1'b0;
      wb_1_d = 1'b0;    wb_2_d = 1'b0;
      load_1_d = 1'b0;  load_2_d = 1'b0;
      state_d = ST_RUN;
    end else if (bus.ex_hold) begin
      stall_s = 1'b1;
    end else if ((state_q == ST_RUN) && lu_s) begin
      valid_1_d = 1'b0; valid_2_d = 1'b0;
      wb_1_d = 1'b0;    wb_2_d = 1'b0;
      load_1_d = 1'b0;  load_2_d = 1'b0;
      state_d = ST_BUBBLE;
      stall_s = 1'b1;
      stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
    end else begin
      op_a_d = res_a_s;  op_b_d = res_b_s;  op_c_d = res_c_s;  op_d_d = res_d_s;
      dest_1_d = bus.dest_1_ID_RF;    dest_2_d = bus.dest_2_ID_RF;
      valid_1_d = bus.valid1_ID_RF;   valid_2_d = bus.valid2_ID_RF;
      wb_1_d = bus.wb_1_ID_RF;        wb_2_d = bus.wb_2_ID_RF;
      load_1_d = bus.load_1_ID_RF;    load_2_d = bus.load_2_ID_RF;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q <= '0;  op_b_q <= '0;  op_c_q <= '0;  op_d_q <= '0;
      dest_1_q <= 3'd0;   dest_2_q <= 3'd0;
      valid_1_q <= 1'b0;  valid_2_q <= 1'b0;
      wb_1_q <= 1'b0;     wb_2_q <= 1'b0;
      load_1_q <= 1'b0;   load_2_q <= 1'b0;
      state_q <= ST_RUN;
      stall_cnt_q <= STALL_CNT_INIT;
    end else begin
      op_a_q <= op_a_d;  op_b_q <= op_b_d;  op_c_q <= op_c_d;  op_d_q <= op_d_d;
      dest_1_q <= dest_1_d;   dest_2_q <= dest_2_d;
      valid_1_q <= valid_1_d; valid_2_q <= valid_2_d;
      wb_1_q <= wb_1_d;       wb_2_q <= wb_2_d;
      load_1_q <= load_1_d;   load_2_q <= load_2_d;
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.opA_RF_EX = op_a_q;
  assign bus.opB_RF_EX = op_b_q;
  assign bus.opC_RF_EX = op_c_q;
  assign bus.opD_RF_EX = op_d_q;
  assign bus.dest_1_RF_EX = dest_1_q;
  assign bus.dest_2_RF_EX = dest_2_q;
  assign bus.valid1_RF_EX = valid_1_q;
  assign bus.valid2_RF_EX = valid_2_q;
  assign bus.wb_1_RF_EX = wb_1_q;
  assign bus.wb_2_RF_EX = wb_2_q;
  assign bus.load_1_RF_EX = load_1_q;
  assign bus.load_2_RF_EX = load_2_q;
  assign bus.stall_ID = stall_s;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_rf_ex_stage.sv
// Randomised bench for rf_ex_stage against a spec-level model; a second
// instance with a preset stall counter exercises saturation.
module tb_rf_ex_stage;
  localparam int DW = 16;
  localparam int VW = 4*DW + 12;
  localparam logic [VW-1:0] FLAG_MASK = 76'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_ex_stage_if #(.DATA_W(DW)) bus ();
  rf_ex_stage_if #(.DATA_W(DW)) sat_bus ();

  rf_ex_stage #(.DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  rf_ex_stage #(.DATA_W(DW), .STALL_CNT_INIT(16'hFFFD)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sat_bus));

  assign sat_bus.opA_RF = bus.opA_RF;            assign sat_bus.opB_RF = bus.opB_RF;
  assign sat_bus.opC_RF = bus.opC_RF;            assign sat_bus.opD_RF = bus.opD_RF;
  assign sat_bus.mux_controller_A = bus.mux_controller_A;
  assign sat_bus.mux_controller_B = bus.mux_controller_B;
  assign sat_bus.mux_controller_C = bus.mux_controller_C;
  assign sat_bus.mux_controller_D = bus.mux_controller_D;
  assign sat_bus.alu_1_EX = bus.alu_1_EX;        assign sat_bus.alu_2_EX = bus.alu_2_EX;
  assign sat_bus.data_1_EX_M = bus.data_1_EX_M;  assign sat_bus.data_2_EX_M = bus.data_2_EX_M;
  assign sat_bus.data_1_M_WB = bus.data_1_M_WB;  assign sat_bus.data_2_M_WB = bus.data_2_M_WB;
  assign sat_bus.valid1_ID_RF = bus.valid1_ID_RF; assign sat_bus.valid2_ID_RF = bus.valid2_ID_RF;
  assign sat_bus.wb_1_ID_RF = bus.wb_1_ID_RF;    assign sat_bus.wb_2_ID_RF = bus.wb_2_ID_RF;
  assign sat_bus.load_1_ID_RF = bus.load_1_ID_RF; assign sat_bus.load_2_ID_RF = bus.load_2_ID_RF;
  assign sat_bus.dest_1_ID_RF = bus.dest_1_ID_RF; assign sat_bus.dest_2_ID_RF = bus.dest_2_ID_RF;
  assign sat_bus.flush = bus.flush;              assign sat_bus.ex_hold = bus.ex_hold;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.opA_RF_EX, bus.opB_RF_EX, bus.opC_RF_EX, bus.opD_RF_EX,
                    bus.dest_1_RF_EX, bus.dest_2_RF_EX, bus.valid1_RF_EX, bus.valid2_RF_EX,
                    bus.wb_1_RF_EX, bus.wb_2_RF_EX, bus.load_1_RF_EX, bus.load_2_RF_EX};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the RF_EX register should hold, per lane.
  logic [DW-1:0] m_op [4];
  logic [2:0]    m_dest [2];
  logic          m_v [2];
  logic          m_wb [2];
  logic          m_ld [2];
  bit            m_known = 1'b1;
  bit            m_bubble = 1'b0;
  int            m_cnt = 0;

  function automatic logic [DW-1:0] m_resolve(input logic [2:0] code, input logic [DW-1:0] rf);
    logic [DW-1:0] src [8];
    src[0] = rf;              src[7] = rf;
    src[1] = bus.alu_1_EX;    src[2] = bus.alu_2_EX;
    src[3] = bus.data_1_EX_M; src[4] = bus.data_2_EX_M;
    src[5] = bus.data_1_M_WB; src[6] = bus.data_2_M_WB;
    return src[code];
  endfunction

  function automatic bit m_lu();
    logic [2:0] sel [4];
    logic       lane_v [2];
    bit         lu;
    sel[0] = bus.mux_controller_A; sel[1] = bus.mux_controller_B;
    sel[2] = bus.mux_controller_C; sel[3] = bus.mux_controller_D;
    lane_v[0] = bus.valid1_ID_RF;  lane_v[1] = bus.valid2_ID_RF;
    lu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lane_v[i/2] && ((sel[i] == 3'd1 && m_v[0] && m_ld[0]) ||
                          (sel[i] == 3'd2 && m_v[1] && m_ld[1])))
        lu = 1'b1;
    end
    return lu;
  endfunction

  function automatic bit m_stall();
    if (!rst_n) return 1'b0;
    if (bus.flush) return 1'b0;
    if (bus.ex_hold) return 1'b1;
    return !m_bubble && m_lu();
  endfunction

  function automatic logic [VW-1:0] m_vec();
    return {m_op[0], m_op[1], m_op[2], m_op[3], m_dest[0], m_dest[1],
            m_v[0], m_v[1], m_wb[0], m_wb[1], m_ld[0], m_ld[1]};
  endfunction

  function automatic logic [VW-1:0] m_mask();
    return m_known ? {VW{1'b1}} : FLAG_MASK;
  endfunction

  function automatic logic [15:0] exp_cnt();
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
  endfunction

  function automatic logic [15:0] exp_sat();
    return (m_cnt + 65533 > 65535) ? 16'hFFFF : 16'(m_cnt + 65533);
  endfunction

  task automatic kill_flags();
    for (int l = 0; l < 2; l++) begin
      m_v[l] = 1'b0; m_wb[l] = 1'b0; m_ld[l] = 1'b0;
    end
    m_known = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then the DUT.
  task automatic tick();
    bit lu;
    lu = m_lu();
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_op[i] = '0;
      for (int l = 0; l < 2; l++) begin
        m_dest[l] = 3'd0; m_v[l] = 1'b0; m_wb[l] = 1'b0; m_ld[l] = 1'b0;
      end
      m_known = 1'b1; m_bubble = 1'b0; m_cnt = 0;
    end else if (bus.flush) begin
      kill_flags(); m_bubble = 1'b0;
    end else if (bus.ex_hold) begin
      m_bubble = m_bubble;
    end else if (!m_bubble && lu) begin
      kill_flags(); m_bubble = 1'b1; m_cnt++;
    end else begin
      m_op[0] = m_resolve(bus.mux_controller_A, bus.opA_RF);
      m_op[1] = m_resolve(bus.mux_controller_B, bus.opB_RF);
      m_op[2] = m_resolve(bus.mux_controller_C, bus.opC_RF);
      m_op[3] = m_resolve(bus.mux_controller_D, bus.opD_RF);
      m_dest[0] = bus.dest_1_ID_RF;  m_dest[1] = bus.dest_2_ID_RF;
      m_v[0] = bus.valid1_ID_RF;     m_v[1] = bus.valid2_ID_RF;
      m_wb[0] = bus.wb_1_ID_RF;      m_wb[1] = bus.wb_2_ID_RF;
      m_ld[0] = bus.load_1_ID_RF;    m_ld[1] = bus.load_2_ID_RF;
      m_known = 1'b1; m_bubble = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.opA_RF = '0; bus.opB_RF = '0; bus.opC_RF = '0; bus.opD_RF = '0;
    bus.mux_controller_A = 3'd0; bus.mux_controller_B = 3'd0;
    bus.mux_controller_C = 3'd0; bus.mux_controller_D = 3'd0;
    bus.alu_1_EX = '0; bus.alu_2_EX = '0; bus.data_1_EX_M = '0; bus.data_2_EX_M = '0;
    bus.data_1_M_WB = '0; bus.data_2_M_WB = '0;
    bus.valid1_ID_RF = 1'b0; bus.valid2_ID_RF = 1'b0; bus.wb_1_ID_RF = 1'b0; bus.wb_2_ID_RF = 1'b0;
    bus.load_1_ID_RF = 1'b0; bus.load_2_ID_RF = 1'b0;
    bus.dest_1_ID_RF = 3'd0; bus.dest_2_ID_RF = 3'd0;
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.opA_RF = 16'($urandom); bus.opB_RF = 16'($urandom);
    bus.opC_RF = 16'($urandom); bus.opD_RF = 16'($urandom);
    bus.mux_controller_A = 3'($urandom); bus.mux_controller_B = 3'($urandom);
    bus.mux_controller_C = 3'($urandom); bus.mux_controller_D = 3'($urandom);
    bus.alu_1_EX = 16'($urandom); bus.alu_2_EX = 16'($urandom);
    bus.data_1_EX_M = 16'($urandom); bus.data_2_EX_M = 16'($urandom);
    bus.data_1_M_WB = 16'($urandom); bus.data_2_M_WB = 16'($urandom);
    bus.valid1_ID_RF = 1'($urandom); bus.valid2_ID_RF = 1'($urandom);
    bus.wb_1_ID_RF = 1'($urandom); bus.wb_2_ID_RF = 1'($urandom);
    bus.load_1_ID_RF = 1'($urandom); bus.load_2_ID_RF = 1'($urandom);
    bus.dest_1_ID_RF = 3'($urandom); bus.dest_2_ID_RF = 3'($urandom);
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rand_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.stall_ID !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", bus.stall_ID); end
    tick();
    n_cmp++; if (dut_vec !== {VW{1'b0}}) begin n_err++; $display("FAIL reset_regs: got %h expected 0", dut_vec); end
    n_cmp++; if (bus.stall_count !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h expected 0000", bus.stall_count); end
    n_cmp++; if (sat_bus.stall_count !== 16'hFFFD) begin n_err++; $display("FAIL reset_sat_count: got %h expected fffd", sat_bus.stall_count); end
    n_cmp++; if (bus.stall_ID !== 1'b0) begin n_err++; $display("FAIL reset_stall_held: got %b expected 0", bus.stall_ID); end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    clear_inputs();
    bus.mux_controller_A = 3'b011; bus.mux_controller_B = 3'b000;
    bus.opB_RF = 16'h0005; bus.data_1_EX_M = 16'h1234; bus.valid1_ID_RF = 1'b1;
    tick();
    n_cmp++; if (bus.opA_RF_EX !== 16'h1234) begin n_err++; $display("FAIL fwd_opA: got %h expected 1234", bus.opA_RF_EX); end
    n_cmp++; if (bus.opB_RF_EX !== 16'h0005) begin n_err++; $display("FAIL fwd_opB: got %h expected 0005", bus.opB_RF_EX); end
    n_cmp++; if (bus.valid1_RF_EX !== 1'b1) begin n_err++; $display("FAIL fwd_valid1: got %b expected 1", bus.valid1_RF_EX); end
    for (int code = 0; code < 8; code++) begin
      rand_inputs();
      bus.load_1_ID_RF = 1'b0; bus.load_2_ID_RF = 1'b0;
      bus.mux_controller_A = 3'(code);     bus.mux_controller_B = 3'(7 - code);
      bus.mux_controller_C = 3'(code + 3); bus.mux_controller_D = 3'(code + 5);
      tick();
      n_cmp++; if ((dut_vec & m_mask()) !== (m_vec() & m_mask())) begin
        n_err++; $display("FAIL fwd_code%0d: got %h expected %h", code, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_load_use();
    logic [DW-1:0] fwd;
    do_reset();
    clear_inputs();
    bus.valid1_ID_RF = 1'b1; bus.load_1_ID_RF = 1'b1; bus.wb_1_ID_RF = 1'b1; bus.dest_1_ID_RF = 3'd5;
    tick();
    clear_inputs();
    bus.valid1_ID_RF = 1'b1; bus.mux_controller_A = 3'b001;
    #1;
    n_cmp++; if (bus.stall_ID !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b expected 1", bus.stall_ID); end
    tick();
    n_cmp++; if ({bus.valid1_RF_EX, bus.valid2_RF_EX} !== 2'b00) begin
      n_err++; $display("FAIL lu_bubble: got %b%b expected 00", bus.valid1_RF_EX, bus.valid2_RF_EX);
    end
    n_cmp++; if (bus.stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count: got %h expected 0001", bus.stall_count); end
    fwd = 16'($urandom);
    bus.mux_controller_A = 3'b011; bus.data_1_EX_M = fwd;
    #1;
    n_cmp++; if (bus.stall_ID !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b expected 0", bus.stall_ID); end
    tick();
    n_cmp++; if (bus.valid1_RF_EX !== 1'b1 || bus.opA_RF_EX !== fwd) begin
      n_err++; $display("FAIL lu_capture: got %b/%h expected 1/%h", bus.valid1_RF_EX, bus.opA_RF_EX, fwd);
    end
  endtask

  task automatic test_lane2_invalid();
    logic [15:0] cnt0;
    clear_inputs();
    bus.valid2_ID_RF = 1'b1; bus.load_2_ID_RF = 1'b1;
    tick();
    cnt0 = exp_cnt();
    clear_inputs();
    bus.mux_controller_C = 3'b010;
    #1;
    n_cmp++; if (bus.stall_ID !== 1'b0) begin n_err++; $display("FAIL l2inv_stall: got %b expected 0", bus.stall_ID); end
    tick();
    n_cmp++; if (bus.stall_count !== cnt0) begin n_err++; $display("FAIL l2inv_count: got %h expected %h", bus.stall_count, cnt0); end
  endtask

  task automatic test_flush_hold();
    clear_inputs();
    bus.valid1_ID_RF = 1'b1; bus.load_1_ID_RF = 1'b1;
    tick();
    bus.load_1_ID_RF = 1'b0; bus.mux_controller_B = 3'b001;
    tick();
    rand_inputs();
    bus.valid1_ID_RF = 1'b1; bus.valid2_ID_RF = 1'b1; bus.load_1_ID_RF = 1'b1; bus.load_2_ID_RF = 1'b1;
    bus.wb_1_ID_RF = 1'b1; bus.wb_2_ID_RF = 1'b1;
    bus.flush = 1'b1; bus.ex_hold = 1'b1;
    #1;
    n_cmp++; if (bus.stall_ID !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b expected 0", bus.stall_ID); end
    tick();
    n_cmp++; if (dut_vec[5:0] !== 6'b000000) begin n_err++; $display("FAIL flush_flags: got %b expected 000000", dut_vec[5:0]); end
    rand_inputs();
    bus.mux_controller_A = 3'd0; bus.mux_controller_B = 3'd6;
    bus.mux_controller_C = 3'd7; bus.mux_controller_D = 3'd4;
    tick();
    n_cmp++; if ((dut_vec & m_mask()) !== (m_vec() & m_mask())) begin
      n_err++; $display("FAIL flush_recover: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_hold();
    logic [VW-1:0] held;
    logic [15:0]   cnt0;
    rand_inputs();
    bus.mux_controller_A = 3'd0; bus.mux_controller_B = 3'd0;
    bus.mux_controller_C = 3'd0; bus.mux_controller_D = 3'd0;
    bus.valid1_ID_RF = 1'b1; bus.load_1_ID_RF = 1'b1;
    tick();
    held = m_vec();
    cnt0 = exp_cnt();
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      bus.valid1_ID_RF = 1'b1; bus.mux_controller_A = 3'b001;
      bus.ex_hold = 1'b1;
      #1;
      n_cmp++; if (bus.stall_ID !== 1'b1) begin n_err++; $display("FAIL hold_stall%0d: got %b expected 1", c, bus.stall_ID); end
      tick();
      n_cmp++; if (dut_vec !== held) begin n_err++; $display("FAIL hold_regs%0d: got %h expected %h", c, dut_vec, held); end
      n_cmp++; if (bus.stall_count !== cnt0) begin n_err++; $display("FAIL hold_count%0d: got %h expected %h", c, bus.stall_count, cnt0); end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] want;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      clear_inputs();
      bus.valid1_ID_RF = 1'b1; bus.load_1_ID_RF = 1'b1;
      tick();
      clear_inputs();
      bus.valid1_ID_RF = 1'b1; bus.mux_controller_A = 3'b001;
      tick();
      want = (k >= 2) ? 16'hFFFF : 16'(16'hFFFD + k);
      n_cmp++; if (sat_bus.stall_count !== want) begin n_err++; $display("FAIL sat_count%0d: got %h expected %h", k, sat_bus.stall_count, want); end
      n_cmp++; if (bus.stall_count !== 16'(k)) begin n_err++; $display("FAIL sat_main%0d: got %h expected %h", k, bus.stall_count, 16'(k)); end
    end
  endtask

  task automatic test_reset_in_bubble();
    clear_inputs();
    bus.valid2_ID_RF = 1'b1; bus.load_2_ID_RF = 1'b1;
    tick();
    rand_inputs();
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
    bus.valid1_ID_RF = 1'b1; bus.mux_controller_A = 3'b010;
    tick();
    rand_inputs();
    bus.valid1_ID_RF = 1'b1; bus.valid2_ID_RF = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.stall_ID !== 1'b0) begin n_err++; $display("FAIL rstbub_stall: got %b expected 0", bus.stall_ID); end
    tick();
    n_cmp++; if (dut_vec !== {VW{1'b0}}) begin n_err++; $display("FAIL rstbub_regs: got %h expected 0", dut_vec); end
    n_cmp++; if (bus.stall_count !== 16'h0000) begin n_err++; $display("FAIL rstbub_count: got %h expected 0000", bus.stall_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      bus.flush = ($urandom_range(15) == 0);
      bus.ex_hold = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(63) != 0);
      #1;
      n_cmp++; if (bus.stall_ID !== m_stall()) begin n_err++; $display("FAIL rnd_stall@%0d: got %b expected %b", n, bus.stall_ID, m_stall()); end
      tick();
      n_cmp++; if ((dut_vec & m_mask()) !== (m_vec() & m_mask())) begin
        n_err++; $display("FAIL rnd_regs@%0d: got %h expected %h", n, dut_vec, m_vec());
      end
      n_cmp++; if (bus.stall_count !== exp_cnt()) begin n_err++; $display("FAIL rnd_count@%0d: got %h expected %h", n, bus.stall_count, exp_cnt()); end
      n_cmp++; if (sat_bus.stall_count !== exp_sat()) begin n_err++; $display("FAIL rnd_sat@%0d: got %h expected %h", n, sat_bus.stall_count, exp_sat()); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_op[i] = '0;
    for (int l = 0; l < 2; l++) begin
      m_dest[l] = 3'd0; m_v[l] = 1'b0; m_wb[l] = 1'b0; m_ld[l] = 1'b0;
    end
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_lane2_invalid();
    test_flush_hold();
    test_hold();
    test_saturate();
    test_reset_in_bubble();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
